// File: rtl/wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wb_arbiter_pkg
// Shared types and constants for the writeback arbiter and its consumers.
//   fu_wb_t       : completion packet carried from an FU to the ROB writeback
//   WB_ARB_MAX_FU : largest supported number of FU result ports
//   sat_add32     : saturating 32-bit add used by the optional stat counters
// -----------------------------------------------------------------------------
package wb_arbiter_pkg;

  localparam int WB_ARB_MAX_FU = 8;
  localparam int EPOCH_W       = 2;
  localparam int ROB_IDX_W     = 6;
  localparam int RESULT_W      = 32;

  typedef struct packed {
    logic [EPOCH_W-1:0]   epoch;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic                 exc;
    logic [RESULT_W-1:0]  result;
  } fu_wb_t;

  // Sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [3:0] inc);
    logic [32:0] sum;
    sum = {1'b0, a} + {29'b0, inc};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/wb_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. The request at index ptr has the
// highest priority, then ptr+1, ... wrapping modulo N (also for N that is not
// a power of two). The pointer register lives in the parent.
//   req       in  N   request vector
//   ptr       in  W   highest-priority index (must be < N)
//   grant     out N   one-hot grant, zero when no request
//   grant_idx out W   index of the granted request (0 when none)
//   grant_any out 1   any request granted
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx,
  output logic         grant_any
);

  function automatic logic [W-1:0] slot(input logic [W-1:0] p, input int k);
    int s;
    s = (int'(p) + k) % N;
    return W'(s);
  endfunction

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!grant_any && req[slot(ptr, k)]) begin
        grant[slot(ptr, k)] = 1'b1;
        grant_idx           = slot(ptr, k);
        grant_any           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Serialises completion packets from N_FU functional units onto the single
// ROB writeback channel through a one-entry registered output stage, with
// round-robin arbitration. Packets from a stale epoch are consumed and dropped
// without arbitrating; flush empties the output stage.
//
// Optional feature: define WB_ARB_STATS_EN to add saturating stat counters.
//
// Ports
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   fu_valid       in   N_FU  per-FU packet valid
//   fu_ready       out  N_FU  per-FU accept (combinational)
//   fu_pkt         in   N_FU x fu_wb_t  per-FU packet
//   wb_valid       out  writeback valid (suppressed while held packet is stale)
//   wb_ready       in   ROB ready
//   wb_pkt         out  registered writeback packet
//   flush_valid    in   pipeline flush
//   global_epoch   in   current epoch from the ROB
//   stat_grant_cnt out  N_FU x 32 accepted packets per FU   (WB_ARB_STATS_EN)
//   stat_stall_cnt out  32 cycles with wb_valid & ~wb_ready (WB_ARB_STATS_EN)
//   stat_drop_cnt  out  32 stale packets discarded          (WB_ARB_STATS_EN)
// -----------------------------------------------------------------------------
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int N_FU = 4,
  parameter int FU_W = $clog2(N_FU)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_FU-1:0]      fu_valid,
  output logic [N_FU-1:0]      fu_ready,
  input  fu_wb_t [N_FU-1:0]    fu_pkt,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output fu_wb_t               wb_pkt,
  input  logic                 flush_valid,
  input  logic [EPOCH_W-1:0]   global_epoch
`ifdef WB_ARB_STATS_EN
  ,
  output logic [N_FU-1:0][31:0] stat_grant_cnt,
  output logic [31:0]           stat_stall_cnt,
  output logic [31:0]           stat_drop_cnt
`endif
);

  logic              out_valid_q, out_valid_d;
  fu_wb_t            out_pkt_q,   out_pkt_d;
  logic [FU_W-1:0]   rr_ptr_q,    rr_ptr_d;

  logic [N_FU-1:0]   stale;
  logic [N_FU-1:0]   req;
  logic [N_FU-1:0]   grant;
  logic [FU_W-1:0]   grant_idx;
  logic              grant_any;
  logic              out_stale;
  logic              load;
  logic              accept;

  always_comb begin
    stale = '0;
    req   = '0;
    for (int i = 0; i < N_FU; i++) begin
      stale[i] = fu_valid[i] & (fu_pkt[i].epoch != global_epoch);
      req[i]   = fu_valid[i] & (fu_pkt[i].epoch == global_epoch);
    end
  end

  rr_arbiter #(
    .N (N_FU),
    .W (FU_W)
  ) u_rr (
    .req       (req),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // A held packet whose epoch has gone stale is never presented, so it must
  // not block the stage: it is overwritten or retired on the next edge.
  assign out_stale = out_valid_q & (out_pkt_q.epoch != global_epoch);
  assign wb_valid  = out_valid_q & ~out_stale;
  assign wb_pkt    = out_pkt_q;
  assign load      = ~out_valid_q | wb_ready | out_stale;
  assign accept    = load & grant_any & ~flush_valid;

  // Stale packets are drained regardless of the output stage. rst_n gating
  // keeps every FU from handshaking while the block is held in reset.
  assign fu_ready = {N_FU{rst_n & ~flush_valid}} & (stale | (grant & {N_FU{load}}));

  always_comb begin
    out_valid_d = out_valid_q;
    out_pkt_d   = out_pkt_q;
    rr_ptr_d    = rr_ptr_q;
    if (flush_valid) begin
      out_valid_d = 1'b0;
    end else if (load) begin
      if (accept) begin
        out_valid_d = 1'b1;
        out_pkt_d   = fu_pkt[grant_idx];
        rr_ptr_d    = (grant_idx == FU_W'(N_FU - 1)) ? '0 : grant_idx + FU_W'(1);
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_pkt_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_pkt_q   <= out_pkt_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

`ifdef WB_ARB_STATS_EN
  logic [N_FU-1:0]       take_vec;
  logic [N_FU-1:0]       drop_vec;
  logic [3:0]            drop_num;
  logic [N_FU-1:0][31:0] grant_cnt_q;
  logic [31:0]           stall_cnt_q;
  logic [31:0]           drop_cnt_q;

  assign take_vec = fu_ready & req;
  assign drop_vec = fu_ready & stale;

  // Several FUs can drop a stale packet in the same cycle.
  always_comb begin
    drop_num = '0;
    for (int i = 0; i < N_FU; i++) begin
      drop_num = drop_num + {3'b0, drop_vec[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      for (int i = 0; i < N_FU; i++) begin
        if (take_vec[i]) begin
          grant_cnt_q[i] <= sat_add32(grant_cnt_q[i], 4'd1);
        end
      end
      if (wb_valid & ~wb_ready) begin
        stall_cnt_q <= sat_add32(stall_cnt_q, 4'd1);
      end
      drop_cnt_q <= sat_add32(drop_cnt_q, drop_num);
    end
  end

  assign stat_grant_cnt = grant_cnt_q;
  assign stat_stall_cnt = stall_cnt_q;
  assign stat_drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     fu_valid;
  logic [N-1:0]     fu_ready;
  fu_wb_t [N-1:0]   fu_pkt;
  logic             wb_valid;
  logic             wb_ready;
  fu_wb_t           wb_pkt;
  logic             flush_valid;
  logic [1:0]       global_epoch;
`ifdef WB_ARB_STATS_EN
  logic [N-1:0][31:0] stat_grant_cnt;
  logic [31:0]        stat_stall_cnt;
  logic [31:0]        stat_drop_cnt;
`endif

  wb_arbiter #(.N_FU(N)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fu_valid       (fu_valid),
    .fu_ready       (fu_ready),
    .fu_pkt         (fu_pkt),
    .wb_valid       (wb_valid),
    .wb_ready       (wb_ready),
    .wb_pkt         (wb_pkt),
    .flush_valid    (flush_valid),
    .global_epoch   (global_epoch)
`ifdef WB_ARB_STATS_EN
    ,
    .stat_grant_cnt (stat_grant_cnt),
    .stat_stall_cnt (stat_stall_cnt),
    .stat_drop_cnt  (stat_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: one output slot, a priority pointer, and counters.
  bit           m_valid;
  fu_wb_t       m_pkt;
  int           m_ptr;
  logic [N-1:0] m_ready;
  bit           m_wbv;
  bit           m_load;
  bit           m_found;
  int           m_g;
  int           m_ndrop;
  int unsigned  m_grant_cnt [N];
  int unsigned  m_stall;
  int unsigned  m_drop;

  logic [N-1:0] obs_ready;
  logic         obs_wbv;
  fu_wb_t       obs_pkt;

  task automatic model_reset();
    m_valid = 0;
    m_pkt   = '0;
    m_ptr   = 0;
    m_stall = 0;
    m_drop  = 0;
    for (int i = 0; i < N; i++) m_grant_cnt[i] = 0;
  endtask

  task automatic model_eval();
    m_wbv   = m_valid && (m_pkt.epoch == global_epoch);
    m_load  = !m_valid || wb_ready || (m_pkt.epoch != global_epoch);
    m_ready = '0;
    m_found = 0;
    m_g     = 0;
    m_ndrop = 0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (!m_found && fu_valid[idx] && fu_pkt[idx].epoch == global_epoch) begin
        m_found = 1;
        m_g     = idx;
      end
    end
    if (!flush_valid) begin
      for (int i = 0; i < N; i++)
        if (fu_valid[i] && fu_pkt[i].epoch != global_epoch) begin
          m_ready[i] = 1'b1;
          m_ndrop++;
        end
      if (m_load && m_found) m_ready[m_g] = 1'b1;
    end
  endtask

  task automatic model_commit();
    if (m_wbv && !wb_ready) m_stall++;
    if (flush_valid) begin
      m_valid = 0;
    end else begin
      m_drop += m_ndrop;
      if (m_load) begin
        if (m_found) begin
          m_grant_cnt[m_g]++;
          m_valid = 1;
          m_pkt   = fu_pkt[m_g];
          m_ptr   = (m_g + 1) % N;
        end else begin
          m_valid = 0;
        end
      end
    end
  endtask

  // One clock: check at the falling edge, advance the model at the rising
  // edge, then let the FU drivers retire accepted or flushed packets.
  task automatic cycle();
    @(negedge clk);
    model_eval();
    obs_ready = fu_ready;
    obs_wbv   = wb_valid;
    obs_pkt   = wb_pkt;
    check_eq("fu_ready", 64'(fu_ready), 64'(m_ready));
    check_eq("wb_valid", 64'(wb_valid), 64'(m_wbv));
    if (m_wbv) check_eq("wb_pkt", 64'(wb_pkt), 64'(m_pkt));
`ifdef WB_ARB_STATS_EN
    for (int i = 0; i < N; i++) check_eq("stat_grant", 64'(stat_grant_cnt[i]), 64'(m_grant_cnt[i]));
    check_eq("stat_stall", 64'(stat_stall_cnt), 64'(m_stall));
    check_eq("stat_drop", 64'(stat_drop_cnt), 64'(m_drop));
`endif
    @(posedge clk);
    model_commit();
    #1;
    if (flush_valid) fu_valid = '0;
    for (int i = 0; i < N; i++) if (m_ready[i]) fu_valid[i] = 1'b0;
  endtask

  function automatic fu_wb_t mk_pkt(input logic [1:0] ep, input logic [5:0] rob);
    fu_wb_t p;
    p.epoch   = ep;
    p.rob_idx = rob;
    p.exc     = 1'($urandom_range(0, 1));
    p.result  = $urandom;
    return p;
  endfunction

  task automatic refill_all();
    for (int i = 0; i < N; i++)
      if (!fu_valid[i]) begin
        fu_valid[i] = 1'b1;
        fu_pkt[i]   = mk_pkt(global_epoch, 6'($urandom_range(0, 63)));
      end
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    fu_valid     = '0;
    fu_pkt       = '0;
    wb_ready     = 1'b0;
    flush_valid  = 1'b0;
    global_epoch = 2'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  fu_wb_t pkt_a, pkt_b;

  initial begin
    // Reset state with live and stale requests present
    rst_n        = 1'b0;
    flush_valid  = 1'b0;
    global_epoch = 2'd0;
    wb_ready     = 1'b1;
    fu_pkt       = '0;
    fu_pkt[0].epoch = 2'd1;
    fu_valid     = '1;
    #3;
    check_eq("rst_wb_valid", 64'(wb_valid), 64'd0);
    check_eq("rst_fu_ready", 64'(fu_ready), 64'd0);
    check_eq("rst_wb_pkt", 64'(wb_pkt), 64'd0);
`ifdef WB_ARB_STATS_EN
    check_eq("rst_stat_drop", 64'(stat_drop_cnt), 64'd0);
`endif

    // Single FU1 packet, then pointer must have moved to FU2
    do_reset();
    wb_ready    = 1'b1;
    fu_valid[1] = 1'b1;
    fu_pkt[1]   = mk_pkt(2'd0, 6'd5);
    cycle();
    check_eq("single_accept", 64'(obs_ready), 64'b0010);
    cycle();
    check_eq("single_wbv", 64'(obs_wbv), 64'd1);
    check_eq("single_rob", 64'(obs_pkt.rob_idx), 64'd5);
    refill_all();
    cycle();
    check_eq("ptr_after_fu1", 64'(obs_ready), 64'b0100);

    // All FUs continuously valid: strict rotation 0,1,2,3,0,...
    do_reset();
    wb_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      refill_all();
      cycle();
      check_eq("rr_seq", 64'(obs_ready), 64'(1) << (c % 4));
    end

    // Stall with FU2 pending, then load on the consume edge
    do_reset();
    wb_ready    = 1'b1;
    pkt_a       = mk_pkt(2'd0, 6'd10);
    pkt_b       = mk_pkt(2'd0, 6'd11);
    fu_valid[2] = 1'b1;
    fu_pkt[2]   = pkt_a;
    cycle();
    fu_valid[2] = 1'b1;
    fu_pkt[2]   = pkt_b;
    wb_ready    = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cycle();
      check_eq("stall_pkt", 64'(obs_pkt), 64'(pkt_a));
      check_eq("stall_ready", 64'(obs_ready), 64'd0);
    end
    wb_ready = 1'b1;
    cycle();
    check_eq("release_ready", 64'(obs_ready), 64'b0100);
    cycle();
    check_eq("release_pkt", 64'(obs_pkt), 64'(pkt_b));

    // Stale packet is drained without producing a writeback
    do_reset();
    wb_ready     = 1'b1;
    global_epoch = 2'd1;
    fu_valid[0]  = 1'b1;
    fu_pkt[0]    = mk_pkt(2'd0, 6'd3);
    cycle();
    check_eq("stale_ready", 64'(obs_ready), 64'b0001);
    check_eq("stale_wbv0", 64'(obs_wbv), 64'd0);
    cycle();
    check_eq("stale_wbv1", 64'(obs_wbv), 64'd0);
`ifdef WB_ARB_STATS_EN
    check_eq("stale_drop_cnt", 64'(stat_drop_cnt), 64'd1);
`endif

    // Flush while the output is held; pointer survives the flush
    do_reset();
    wb_ready    = 1'b1;
    fu_valid[1] = 1'b1;
    fu_pkt[1]   = mk_pkt(2'd0, 6'd20);
    cycle();
    wb_ready    = 1'b0;
    fu_valid[3] = 1'b1;
    fu_pkt[3]   = mk_pkt(2'd0, 6'd21);
    cycle();
    flush_valid = 1'b1;
    cycle();
    check_eq("flush_ready", 64'(obs_ready), 64'd0);
    flush_valid = 1'b0;
    cycle();
    check_eq("flush_wbv", 64'(obs_wbv), 64'd0);
    wb_ready    = 1'b1;
    fu_valid[0] = 1'b1;
    fu_pkt[0]   = mk_pkt(2'd0, 6'd22);
    fu_valid[3] = 1'b1;
    fu_pkt[3]   = mk_pkt(2'd0, 6'd23);
    cycle();
    check_eq("flush_ptr_kept", 64'(obs_ready), 64'b1000);

    // Asynchronous reset in the middle of a stall
    do_reset();
    wb_ready    = 1'b1;
    fu_valid[2] = 1'b1;
    fu_pkt[2]   = mk_pkt(2'd0, 6'd30);
    cycle();
    wb_ready = 1'b0;
    refill_all();
    cycle();
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_wbv", 64'(wb_valid), 64'd0);
    check_eq("arst_ready", 64'(fu_ready), 64'd0);
`ifdef WB_ARB_STATS_EN
    check_eq("arst_grant_cnt", 64'(stat_grant_cnt[2]), 64'd0);
    check_eq("arst_stall_cnt", 64'(stat_stall_cnt), 64'd0);
`endif
    model_reset();
    rst_n    = 1'b1;
    wb_ready = 1'b1;
    cycle();
    check_eq("arst_first_grant", 64'(obs_ready), 64'b0001);

    // Randomised traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      wb_ready    = ($urandom_range(0, 9) < 7);
      flush_valid = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 39) == 0) global_epoch = 2'($urandom_range(0, 3));
      for (int i = 0; i < N; i++)
        if (!fu_valid[i] && $urandom_range(0, 2) == 0) begin
          fu_valid[i] = 1'b1;
          fu_pkt[i]   = mk_pkt(($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : global_epoch,
                               6'($urandom_range(0, 63)));
        end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
